// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite OAM DMA scheduler between the 6502 core and the
// memory/PPU bus. A CPU write to DMA_REG_ADDR stalls the core via rdy and
// copies XFER_LEN bytes from page {data,8'h00} to OAM_DATA_ADDR using
// alternating get/put bus cycles. While idle the block is a transparent mux.
// Optional build macro: OAM_DMA_PERF_CNT_EN (stall-length counter on dma_cycles).
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_out,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  output logic [7:0]  cpu_data_in,
  output logic        rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_ren,
  output logic        bus_wen,
  input  logic [7:0]  bus_data_in,
  output logic        dma_busy,
  output logic [9:0]  dma_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      r_state;
  logic        r_put;
  logic        r_rdy;
  logic        r_busy;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic [7:0]  r_data;

  logic        w_trig;
  logic        w_last_write;

  // A DMA starts only on a CPU write (never a read) to the trigger register.
  assign w_trig       = cpu_wen && (cpu_addr_out == DMA_REG_ADDR);
  assign w_last_write = (r_state == S_WRITE) && (r_idx == LAST_IDX);

  // get/put phase: 0 = get (read) cycle, 1 = put (write) cycle.
  always_ff @(posedge clk) begin
    if (rst) r_put <= 1'b0;
    else     r_put <= ~r_put;
  end

  // DMA sequencer with registered rdy/busy that track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b1;
      r_busy  <= 1'b0;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_page  <= cpu_data_out;
            r_idx   <= 8'h00;
            r_state <= S_HALT;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_HALT: begin
          // The 6502 cannot be held on a write cycle, so wait it out; the
          // first READ must then fall on a get cycle.
          if (!cpu_wen) begin
            if (r_put) r_state <= S_READ;
            else       r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_state <= S_READ;
        end
        S_READ: begin
          r_data  <= bus_data_in;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= S_READ;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bus mux: CPU owns the bus in IDLE/HALT, the DMA engine otherwise.
  always_comb begin
    bus_addr     = cpu_addr_out;
    bus_data_out = cpu_data_out;
    bus_ren      = cpu_ren;
    bus_wen      = cpu_wen;
    case (r_state)
      S_ALIGN: begin
        bus_addr     = {r_page, r_idx};
        bus_data_out = r_data;
        bus_ren      = 1'b0;
        bus_wen      = 1'b0;
      end
      S_READ: begin
        bus_addr     = {r_page, r_idx};
        bus_data_out = r_data;
        bus_ren      = 1'b1;
        bus_wen      = 1'b0;
      end
      S_WRITE: begin
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = r_data;
        bus_ren      = 1'b0;
        bus_wen      = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_data_in = bus_data_in;
  assign rdy         = r_rdy;
  assign dma_busy    = r_busy;

`ifdef OAM_DMA_PERF_CNT_EN
  logic [9:0] r_cnt;
  logic [9:0] r_dma_cycles;

  // Count stalled cycles from HALT through the final WRITE, publish on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 10'd0;
      r_dma_cycles <= 10'd0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_trig) r_cnt <= 10'd0;
      end else begin
        r_cnt <= r_cnt + 10'd1;
      end
      if (w_last_write) r_dma_cycles <= r_cnt + 10'd1;
    end
  end

  assign dma_cycles = r_dma_cycles;
`else
  logic w_unused;
  assign w_unused   = w_last_write;
  assign dma_cycles = 10'd0;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed testbench for oam_dma_ctrl: pass-through, trigger decode, even/odd
// alignment, write-extended halt, reset mid-transfer and restart.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_ren;
  logic        bus_wen;
  logic [7:0]  bus_data_in;
  logic        dma_busy;
  logic [9:0]  dma_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  oam_dma_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .cpu_ren      (cpu_ren),
    .cpu_wen      (cpu_wen),
    .cpu_data_in  (cpu_data_in),
    .rdy          (rdy),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_ren      (bus_ren),
    .bus_wen      (bus_wen),
    .bus_data_in  (bus_data_in),
    .dma_busy     (dma_busy),
    .dma_cycles   (dma_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference get/put phase: cleared by reset, toggles every edge after.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory model: 16'h8000 reads 8'hA5, every other address returns its low byte.
  always_comb begin
    if (bus_addr == 16'h8000) bus_data_in = 8'hA5;
    else                      bus_data_in = bus_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_addr_out = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_ren      = 1'b0;
    cpu_wen      = 1'b0;
  endtask

  task automatic wait_parity(input int p);
    cpu_idle();
    while (cyc[0] != p[0]) tick();
  endtask

  // Issue a trigger write and step until rdy returns high.
  task automatic run_dma(input string name, input logic [7:0] page, input int hold,
                         input int exp_low, input int exp_cycles);
    int low, wr, bad;
    logic [15:0] faddr;
    logic fpar, seen, done;
    low = 0; wr = 0; bad = 0; faddr = 16'h0; fpar = 1'b1; seen = 1'b0; done = 1'b0;
    cpu_idle();
    cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = page;
    #1;
    check({name, "_trig_pass"}, {rdy, bus_wen, bus_addr, bus_data_out}, {1'b1, 1'b1, 16'h4014, page});
    tick();
    for (int c = 0; c < 800; c++) begin
      if (c < hold) begin
        cpu_wen = 1'b1; cpu_addr_out = 16'h01FF; cpu_data_out = 8'h55;
      end else begin
        cpu_idle();
      end
      #1;
      if (rdy) begin
        done = 1'b1;
        break;
      end
      if (c == 0) begin
        check({name, "_busy"}, dma_busy, 1'b1);
        if (hold > 0) check({name, "_halt_pass"}, {bus_wen, bus_addr}, {1'b1, 16'h01FF});
      end
      low++;
      if (bus_ren && !seen) begin
        seen  = 1'b1;
        faddr = bus_addr;
        fpar  = cyc[0];
      end
      if (bus_wen && bus_addr == 16'h2004) begin
        if (bus_data_out != wr[7:0]) bad++;
        wr++;
      end
      tick();
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_rdy_low"}, low, exp_low);
    check({name, "_writes"}, wr, 256);
    check({name, "_bad_data"}, bad, 0);
    check({name, "_first_read"}, {fpar, faddr}, {1'b0, page, 8'h00});
    check({name, "_idle_busy"}, dma_busy, 1'b0);
    check({name, "_dma_cycles"}, dma_cycles, PERF ? exp_cycles : 0);
    cpu_idle();
  endtask

  initial begin
    int wr;
    int late;
    rst = 1'b1;
    cpu_idle();
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("reset_state", {rdy, dma_busy, dma_cycles}, {1'b1, 1'b0, 10'd0});

    // Pass-through read
    cpu_ren = 1'b1; cpu_addr_out = 16'h8000;
    #1;
    check("pt_read", {bus_ren, bus_wen, bus_addr, cpu_data_in, rdy, dma_busy},
          {1'b1, 1'b0, 16'h8000, 8'hA5, 1'b1, 1'b0});
    tick();

    // Non-trigger accesses
    cpu_idle(); cpu_ren = 1'b1; cpu_addr_out = 16'h4014;
    tick();
    cpu_idle(); cpu_wen = 1'b1; cpu_addr_out = 16'h4015; cpu_data_out = 8'h02;
    #1;
    check("pt_write_4015", {bus_wen, bus_addr, bus_data_out}, {1'b1, 16'h4015, 8'h02});
    tick();
    cpu_idle();
    #1;
    check("no_trigger", {rdy, dma_busy}, {1'b1, 1'b0});
    tick();

    wait_parity(0);
    run_dma("even", 8'h02, 0, 513, 513);
    tick();
    wait_parity(1);
    run_dma("odd", 8'h02, 0, 514, 514);
    tick();
    wait_parity(0);
    run_dma("wext", 8'h02, 2, 515, 515);
    tick();

    // Reset after the 100th OAM write
    wait_parity(0);
    cpu_wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = 8'h02;
    tick();
    cpu_idle();
    wr = 0;
    for (int c = 0; c < 400 && wr < 100; c++) begin
      #1;
      if (bus_wen && bus_addr == 16'h2004) wr++;
      tick();
    end
    check("rst_mid_reached", wr, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_state", {rdy, dma_busy, dma_cycles}, {1'b1, 1'b0, 10'd0});
    late = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus_wen && bus_addr == 16'h2004) late++;
      tick();
    end
    check("rst_no_writes", late, 0);

    wait_parity(0);
    run_dma("restart", 8'h02, 0, 513, 513);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- CPU-bus scheduler for sprite OAM DMA. Detects a CPU write to the DMA register, stalls the 6502 core through rdy, takes ownership of the CPU address/data bus, and copies 256 bytes from page {data,8'h00} to the OAM data port.
- Sits between the CPU core and the memory/PPU bus. It is a pass-through mux whenever DMA is idle.
- Each clk edge is one CPU cycle.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a DMA.
- OAM_DATA_ADDR, 16'h2004, write target for every transferred byte.
- XFER_LEN, 256, bytes per DMA; must be at most 256.

Ports:
- clk  in  1  CPU cycle clock.
- rst  in  1  synchronous, active-high reset.
- cpu_addr_out  in  16  CPU address.
- cpu_data_out  in  8  CPU write data.
- cpu_ren  in  1  CPU read strobe.
- cpu_wen  in  1  CPU write strobe.
- cpu_data_in  out  8  read data to CPU; always equals bus_data_in.
- rdy  out  1  CPU ready; 0 stalls the core.
- bus_addr  out  16  muxed bus address.
- bus_data_out  out  8  muxed bus write data.
- bus_ren  out  1  muxed read strobe.
- bus_wen  out  1  muxed write strobe.
- bus_data_in  in  8  memory read data; valid in the same cycle as bus_ren.
- dma_busy  out  1  high in any non-IDLE state.
- dma_cycles  out  10  stall length of the last completed DMA (see Optional Feature).

Behaviour:
- Reset values: state IDLE, rdy=1, dma_busy=0, page=0, idx=0, data latch=0, put_cycle=0, dma_cycles=0.
- put_cycle is a flop that toggles every clk after reset. 0 marks a get (read) cycle; 1 marks a put (write) cycle.
- Bus ownership:
  - IDLE and HALT: bus_* follow cpu_* combinationally.
  - ALIGN, READ, WRITE: DMA drives bus_*. Strobes not named below are 0.
- IDLE:
  - cpu_wen=1 and cpu_addr_out==DMA_REG_ADDR: latch page=cpu_data_out, idx=0, next state HALT.
  - The triggering write still passes through to the bus.
- HALT:
  - rdy=0.
  - If cpu_wen=1, stay in HALT; a CPU write cycle cannot be stalled.
  - Otherwise, if put_cycle==1 next state READ, else next state ALIGN. The first READ must land on a get cycle.
- ALIGN: one idle cycle with ren=0 and wen=0, then READ.
- READ:
  - bus_addr={page,idx}, bus_ren=1.
  - Capture bus_data_in into the data latch at the clk edge.
  - Next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_data_out=data latch, bus_wen=1.
  - If idx==XFER_LEN-1, next state IDLE. Otherwise idx increments and next state READ.
  - idx is 8 bits and never wraps beyond the final write.
- rdy is 0 in HALT, ALIGN, READ and WRITE, and returns to 1 in the first IDLE cycle after the final WRITE.
- Stall length with no pending CPU write: 513 cycles when HALT falls on a put cycle, 514 when HALT falls on a get cycle.
- A trigger write is impossible while busy, because the CPU is stalled. Any matching write seen outside IDLE is ignored.
- A DMA_REG_ADDR match on cpu_ren (a read) does not trigger.
- rst asserted mid-DMA: the next edge forces IDLE and the reset values above. No further bus writes are issued; bytes already written stay written.
- A page of 8'h20 or higher is legal. Reads go to whatever the bus decodes, including registers.

Optional Feature:
- Macro: OAM_DMA_PERF_CNT_EN.
- Defined:
  - A 10-bit counter clears on entry to HALT and increments every cycle with rdy=0.
  - On return to IDLE it is copied to dma_cycles (513 or 514 nominal). It holds until the next completed DMA.
  - A reset mid-DMA clears dma_cycles to 0.
- Undefined: the counter is removed and dma_cycles is tied to 10'd0.

Test Plan:
- Pass-through: CPU read of 16'h8000 with bus_data_in=8'hA5 -> bus_ren=1, bus_addr=16'h8000, cpu_data_in=8'hA5, rdy=1, dma_busy=0.
- Even alignment: write 8'h02 to 16'h4014 so HALT lands on a put cycle; memory[16'h0200+i]=i -> 256 writes to 16'h2004 with data 0..255 in order; rdy low for exactly 513 cycles; dma_cycles=513 with macro.
- Odd alignment: same trigger shifted one cycle so HALT lands on a get cycle -> one ALIGN cycle, rdy low 514 cycles, dma_cycles=514; first READ at 16'h0200 on put_cycle=0.
- Write-extended halt: cpu_wen held high for 2 cycles after the trigger -> HALT lasts 3 cycles, rdy low 515 or 516 cycles, first READ still on a get cycle.
- Reset mid-DMA: assert rst after the 100th write to 16'h2004 -> next cycle rdy=1, dma_busy=0, no further writes to 16'h2004, dma_cycles=0; a new trigger afterwards completes normally.
- Non-trigger: CPU read of 16'h4014 and CPU write to 16'h4015 -> no DMA, rdy stays 1.
